i2s_speaker_tx: RTL

I2S_SPEAKER_TX -- requirements
Module: i2s_speaker_tx

---
 rtl/i2s_speaker_tx_pkg.sv | 15 +
 rtl/i2s_clk_gen.sv | 53 +++++
 rtl/i2s_speaker_tx.sv | 109 ++++++++++
 3 files changed

// File: rtl/i2s_speaker_tx_pkg.sv
// Shared constants for the I2S speaker transmitter.
// Sample width, frame counter width, slot geometry and clock tap positions.
package i2s_speaker_tx_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int DIV_W     = 10;
    localparam int SLOT_BITS = 32;
    localparam int DATA_BITS = 16;

    // Counter taps: mclk = clk/4, sclk = clk/16, lrck = clk/1024
    localparam int MCLK_BIT  = 1;
    localparam int SCLK_BIT  = 3;
    localparam int LRCK_BIT  = 9;

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter and registered I2S clock decode.
// Ports: clk_i, rst_ni, cnt_o (frame position), mclk_o, sclk_o, lrck_o, sample_req_o.
module i2s_clk_gen #(
    parameter int DIV_W = i2s_speaker_tx_pkg::DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [DIV_W-1:0] cnt_o,
    output logic             mclk_o,
    output logic             sclk_o,
    output logic             lrck_o,
    output logic             sample_req_o
);
    import i2s_speaker_tx_pkg::*;

    localparam logic [DIV_W-1:0] ONE     = 1;
    // Decoding one count early lets the registered pulse line up with cnt == max
    localparam logic [DIV_W-1:0] REQ_PRE = {{(DIV_W-1){1'b1}}, 1'b0};

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             mclk_q;
    logic             sclk_q;
    logic             lrck_q;
    logic             req_q;

    always_comb begin
        cnt_d = cnt_q + ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            mclk_q <= 1'b0;
            sclk_q <= 1'b0;
            lrck_q <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mclk_q <= cnt_q[MCLK_BIT];
            sclk_q <= cnt_q[SCLK_BIT];
            lrck_q <= cnt_q[LRCK_BIT];
            req_q  <= (cnt_q == REQ_PRE);
        end
    end

    assign cnt_o        = cnt_q;
    assign mclk_o       = mclk_q;
    assign sclk_o       = sclk_q;
    assign lrck_o       = lrck_q;
    assign sample_req_o = req_q;

endmodule

// File: rtl/i2s_speaker_tx.sv
// I2S transmitter: sample attenuation/mute, per-frame holding registers, serialiser.
// Ports: clk, rst (async low), en, mute, volume, audio_left/right in; mclk, sclk, lrck, sdin, sample_req out.
module i2s_speaker_tx #(
    parameter int SAMPLE_W = i2s_speaker_tx_pkg::SAMPLE_W,
    parameter int DIV_W    = i2s_speaker_tx_pkg::DIV_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mute,
    input  logic [2:0]          volume,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    output logic                mclk,
    output logic                sclk,
    output logic                lrck,
    output logic                sdin,
    output logic                sample_req
);
    import i2s_speaker_tx_pkg::*;

    localparam logic [4:0] DATA_LAST = 5'(DATA_BITS);

    logic [DIV_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] proc_l;
    logic [SAMPLE_W-1:0] proc_r;
    logic [SAMPLE_W-1:0] hold_l_q;
    logic [SAMPLE_W-1:0] hold_l_d;
    logic [SAMPLE_W-1:0] hold_r_q;
    logic [SAMPLE_W-1:0] hold_r_d;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] shifted;
    logic [4:0]          slot_b;
    logic                slot_r;
    logic                bit_start;
    logic                data_bit;
    logic                sdin_q;
    logic                sdin_d;

    i2s_clk_gen #(
        .DIV_W(DIV_W)
    ) u_clk_gen (
        .clk_i       (clk),
        .rst_ni      (rst),
        .cnt_o       (cnt),
        .mclk_o      (mclk),
        .sclk_o      (sclk),
        .lrck_o      (lrck),
        .sample_req_o(sample_req)
    );

    always_comb begin
        proc_l = '0;
        proc_r = '0;
        if (!mute) begin
            proc_l = $signed(audio_left) >>> volume;
            proc_r = $signed(audio_right) >>> volume;
        end
    end

    // sample_req is high exactly while cnt is at the end of the frame
    always_comb begin
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        if (sample_req) begin
            hold_l_d = proc_l;
            hold_r_d = proc_r;
        end
    end

    assign slot_r    = cnt[LRCK_BIT];
    assign slot_b    = cnt[LRCK_BIT-1:SCLK_BIT+1];
    assign bit_start = (cnt[SCLK_BIT:0] == '0);
    assign word      = slot_r ? hold_r_q : hold_l_q;

    // Slot bit b (1..DATA_BITS) carries the word MSB first; bit 0 is the I2S delay
    always_comb begin
        shifted  = word << (slot_b - 5'd1);
        data_bit = 1'b0;
        if (slot_b != 5'd0 && slot_b <= DATA_LAST) begin
            data_bit = shifted[SAMPLE_W-1];
        end
    end

    // Disabling clears sdin at once; enabling waits for the next bit boundary
    always_comb begin
        sdin_d = sdin_q;
        if (!en) begin
            sdin_d = 1'b0;
        end else if (bit_start) begin
            sdin_d = data_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_l_q <= '0;
            hold_r_q <= '0;
            sdin_q   <= 1'b0;
        end else begin
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            sdin_q   <= sdin_d;
        end
    end

    assign sdin = sdin_q;

endmodule
